eth_frame_script_seq: RTL
=========================

Name: eth_frame_script_seq

Overview:
- Instruction sequencer placed directly ahead of the frame loop-edit datapath.
- Holds one instruction RAM per script, indexed by byte offset within the frame.
- For each incoming byte it reads the RAM and presents the per-script {PARAM, INSTR, MATCHED} bundle that the editor consumes.
- Arbitrates a CPU-side configuration write port against datapath reads of the single-port RAMs.

Parameters:
- C_NUM_SCRIPTS, 4, number of scripts (1..16).
- C_SCRIPT_ADDR_WIDTH, 11, RAM address width; script depth D = 2^C_SCRIPT_ADDR_WIDTH bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_axis_tdata  in  8  frame byte
- s_axis_tuser  in  C_NUM_SCRIPTS+1  {MATCHED[C_NUM_SCRIPTS-1:0], FCS_INVALID}
- s_axis_tlast  in  1  last byte of frame
- s_axis_tvalid  in  1  byte valid; no backpressure
- m_axis_tdata  out  8  delayed byte
- m_axis_tuser  out  17*C_NUM_SCRIPTS+1  per script i, bits [17*i+17:17*i+1] = {PARAM[7:0], INSTR[7:0], MATCHED}; bit 0 = FCS_INVALID
- m_axis_tlast  out  1  delayed tlast
- m_axis_tvalid  out  1  delayed tvalid
- cfg_script_en  in  C_NUM_SCRIPTS  per-script enable
- cfg_wr_en  in  1  one-cycle write request
- cfg_wr_script  in  4  target script
- cfg_wr_addr  in  C_SCRIPT_ADDR_WIDTH  byte offset
- cfg_wr_data  in  16  {PARAM, INSTR}
- cfg_busy  out  1  write pending
- cfg_wr_ack  out  1  one-cycle pulse when the write commits

Behaviour:
- Reset:
  - All outputs 0; state IDLE; offset 0; pending write cleared; latched enables 0.
  - RAM contents are not reset.
- Frame FSM (updates only on cycles with s_axis_tvalid=1):
  - IDLE: offset 0; the current byte uses offset 0.
    - Enables are latched from cfg_script_en on this byte and apply to it.
    - ~tlast -> ACTIVE, offset <= 1.
    - tlast -> stay IDLE (single-byte frame).
  - ACTIVE: current byte uses the current offset.
    - tlast -> IDLE, offset <= 0.
    - else if offset == D-1 -> OVERFLOW.
    - else offset++.
  - OVERFLOW: INSTR/PARAM forced to 0 and no RAM read; tlast -> IDLE, offset <= 0.
- Enable latching: cfg_script_en changes mid-frame take effect from the next frame's first byte.
- Read / latency:
  - A RAM read occurs on a valid byte when state != OVERFLOW.
  - Fixed latency of 2 cycles, s_axis -> m_axis, for tdata, tlast, tvalid, FCS_INVALID and MATCHED. RAM data is aligned to the same cycle.
- Output per script i:
  - MATCHED_out = MATCHED_in[i] & en_latched[i].
  - {PARAM, INSTR} = RAM data when MATCHED_out=1 and a read occurred; otherwise 16'h0.
  - When m_axis_tvalid=0, m_axis_tuser and m_axis_tdata are 0.
- Config write arbitration (one-entry request buffer):
  - cfg_wr_en while cfg_busy=0: capture script/addr/data; cfg_busy <= 1 next cycle.
  - cfg_wr_en while cfg_busy=1: ignored, no ack.
  - A pending write commits in the first cycle with no RAM read, which may be the capture cycle's successor. It is never the capture cycle itself.
  - On commit: cfg_wr_ack=1 for one cycle and cfg_busy <= 0 in the same edge.
  - Datapath reads always win. The write is delayed, never dropped; inter-frame gaps guarantee progress.
  - cfg_wr_script >= C_NUM_SCRIPTS: acked on commit, no RAM modified.
- RAM ordering: a read in the cycle after a commit to the same address returns the new data.
- Reset mid-frame:
  - The pipeline is flushed and the pending write is discarded (no ack).
  - After release, the next valid byte is treated as offset 0 of a new frame; upstream is reset together.

Test Plan:
- Write script 0 addr 5 = 16'hAB21 while idle -> cfg_busy high 1 cycle, cfg_wr_ack pulse. Then a 64-byte frame with MATCHED[0]=1, en=4'b0001 -> output byte 5 (2 cycles later) carries INSTR=8'h21, PARAM=8'hAB in script 0 field; all other bytes carry 0.
- Same frame with cfg_script_en[0]=0 at SOF, toggled to 1 at byte 10 -> MATCHED_out[0]=0 for the whole frame; the next frame uses en=1.
- cfg_wr_en during a continuous 100-byte frame -> cfg_busy held high; ack arrives on the first idle cycle after tlast; a second cfg_wr_en while busy produces no ack.
- C_SCRIPT_ADDR_WIDTH=3, 12-byte frame with RAM filled with 8'hFF -> bytes 0-7 carry RAM data; bytes 8-11 carry INSTR=PARAM=0; next frame restarts at offset 0.
- Single-byte frames back-to-back (tvalid=tlast=1 for 3 cycles) -> each reads offset 0; state stays IDLE; m_axis_tlast=1 on all 3 output cycles.
- rst_n asserted at byte 20 with a write pending -> outputs 0 asynchronously, no ack. The byte after release reads offset 0, and a subsequent write acks normally.

Source files
------------

// File: rtl/eth_frame_script_seq.sv
// Per-byte instruction sequencer for the frame loop-edit datapath: one single-port
// instruction RAM per script, read by frame byte offset, with a one-entry CPU write buffer.
module eth_frame_script_seq #(
  parameter int C_NUM_SCRIPTS       = 4,
  parameter int C_SCRIPT_ADDR_WIDTH = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [7:0]                     s_axis_tdata,
  input  logic [C_NUM_SCRIPTS:0]         s_axis_tuser,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tvalid,
  output logic [7:0]                     m_axis_tdata,
  output logic [17*C_NUM_SCRIPTS:0]      m_axis_tuser,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic [C_NUM_SCRIPTS-1:0]       cfg_script_en,
  input  logic                           cfg_wr_en,
  input  logic [3:0]                     cfg_wr_script,
  input  logic [C_SCRIPT_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [15:0]                    cfg_wr_data,
  output logic                           cfg_busy,
  output logic                           cfg_wr_ack
);

  localparam int AW    = C_SCRIPT_ADDR_WIDTH;
  localparam int NS    = C_NUM_SCRIPTS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_OVERFLOW
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   offset_reg, offset_next;
  logic [NS-1:0]   en_reg, en_next, en_cur;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

  // Frame offset tracker; the first byte of a frame always uses offset 0 and the
  // enables sampled on that same byte.
  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    en_next     = en_reg;
    en_cur      = en_reg;
    rd_en       = 1'b0;
    rd_addr     = offset_reg;
    case (state_reg)
      ST_IDLE: begin
        rd_addr = '0;
        en_cur  = cfg_script_en;
        if (s_axis_tvalid) begin
          rd_en   = 1'b1;
          en_next = cfg_script_en;
          if (!s_axis_tlast) begin
            state_next  = ST_ACTIVE;
            offset_next = AW'(1);
          end
        end
      end
      ST_ACTIVE: begin
        if (s_axis_tvalid) begin
          rd_en = 1'b1;
          if (s_axis_tlast) begin
            state_next  = ST_IDLE;
            offset_next = '0;
          end else if (&offset_reg) begin
            state_next = ST_OVERFLOW;
          end else begin
            offset_next = offset_reg + AW'(1);
          end
        end
      end
      ST_OVERFLOW: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_next  = ST_IDLE;
          offset_next = '0;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        offset_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      offset_reg <= '0;
      en_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
      en_reg     <= en_next;
    end
  end

  // Configuration write buffer: datapath reads own the RAM port, a pending write
  // slips into the first cycle without a read.
  logic            busy_reg;
  logic            ack_reg;
  logic [3:0]      wr_script_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic [15:0]     wr_data_reg;
  logic            commit;
  logic            wr_in_range;

  assign commit      = busy_reg & ~rd_en;
  assign wr_in_range = ({1'b0, wr_script_reg} < 5'(NS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      wr_script_reg <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
    end else begin
      ack_reg <= commit;
      if (commit) begin
        busy_reg <= 1'b0;
      end else if (cfg_wr_en && !busy_reg) begin
        busy_reg      <= 1'b1;
        wr_script_reg <= cfg_wr_script;
        wr_addr_reg   <= cfg_wr_addr;
        wr_data_reg   <= cfg_wr_data;
      end
    end
  end

  assign cfg_busy   = busy_reg;
  assign cfg_wr_ack = ack_reg;

  // First pipeline stage runs alongside the RAM read; invalid beats are zeroed here.
  logic            p1_valid;
  logic [7:0]      p1_data;
  logic            p1_last;
  logic            p1_fcs;
  logic [NS-1:0]   p1_matched;
  logic            p1_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid   <= 1'b0;
      p1_data    <= '0;
      p1_last    <= 1'b0;
      p1_fcs     <= 1'b0;
      p1_matched <= '0;
      p1_rd      <= 1'b0;
    end else begin
      p1_valid   <= s_axis_tvalid;
      p1_data    <= s_axis_tvalid ? s_axis_tdata : 8'h00;
      p1_last    <= s_axis_tvalid & s_axis_tlast;
      p1_fcs     <= s_axis_tvalid & s_axis_tuser[0];
      p1_matched <= s_axis_tvalid ? (s_axis_tuser[NS:1] & en_cur) : '0;
      p1_rd      <= rd_en;
    end
  end

  logic fcs_out_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      fcs_out_reg   <= 1'b0;
    end else begin
      m_axis_tvalid <= p1_valid;
      m_axis_tdata  <= p1_data;
      m_axis_tlast  <= p1_last;
      fcs_out_reg   <= p1_fcs;
    end
  end

  assign m_axis_tuser[0] = fcs_out_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_script
      logic [15:0] mem [0:DEPTH-1];
      logic [15:0] rd_data_reg;
      logic [16:0] field_reg;
      logic        ram_we;

      assign ram_we = commit & wr_in_range & (wr_script_reg == 4'(gi));

      // Read and write never share a cycle, so this maps onto a single-port RAM.
      always_ff @(posedge clk) begin
        if (ram_we) begin
          mem[wr_addr_reg] <= wr_data_reg;
        end
        if (rd_en) begin
          rd_data_reg <= mem[rd_addr];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          field_reg <= '0;
        end else if (p1_matched[gi] && p1_rd) begin
          field_reg <= {rd_data_reg, 1'b1};
        end else begin
          field_reg <= {16'h0000, p1_matched[gi]};
        end
      end

      assign m_axis_tuser[17*gi+17:17*gi+1] = field_reg;
    end
  endgenerate

endmodule
